// File: rtl/c1_pkg.sv
// C1 address-decode shared definitions: zone and FSM encodings, A[23:20]
// nibble map, and the vector-swap register addresses used when the
// C1_VECTOR_SWAP_EN build option is enabled.
package c1_pkg;

    typedef enum logic [2:0] {
        ZONE_ROM,
        ZONE_WRAM,
        ZONE_PORT,
        ZONE_IO,
        ZONE_CARD,
        ZONE_SROM,
        ZONE_NONE
    } zoneT;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERROR
    } stateT;

    // A[23:20] values that select each zone; the card window spans four nibbles.
    localparam logic [3:0] NIB_ROM     = 4'h0;
    localparam logic [3:0] NIB_WRAM    = 4'h1;
    localparam logic [3:0] NIB_PORT    = 4'h2;
    localparam logic [3:0] NIB_IO      = 4'h3;
    localparam logic [3:0] NIB_CARD_LO = 4'h8;
    localparam logic [3:0] NIB_CARD_HI = 4'hB;
    localparam logic [3:0] NIB_SROM    = 4'hC;

    // Byte addresses of the vector-swap set/clear registers (odd bytes, nLDS lane).
    localparam logic [23:0] VECT_SET_BYTE = 24'h3A0003;
    localparam logic [23:0] VECT_CLR_BYTE = 24'h3A0013;

    function automatic zoneT decodeNibble(input logic [3:0] nib);
        zoneT z;
        z = ZONE_NONE;
        if (nib == NIB_ROM)
            z = ZONE_ROM;
        else if (nib == NIB_WRAM)
            z = ZONE_WRAM;
        else if (nib == NIB_PORT)
            z = ZONE_PORT;
        else if (nib == NIB_IO)
            z = ZONE_IO;
        else if (nib >= NIB_CARD_LO && nib <= NIB_CARD_HI)
            z = ZONE_CARD;
        else if (nib == NIB_SROM)
            z = ZONE_SROM;
        return z;
    endfunction

    // Address bus carries A[23:1]; compare against the byte address minus A0.
    function automatic logic isVectSet(input logic [22:0] addr);
        return addr == VECT_SET_BYTE[23:1];
    endfunction

    function automatic logic isVectClr(input logic [22:0] addr);
        return addr == VECT_CLR_BYTE[23:1];
    endfunction

    // 0x000000-0x00007F: the 68K exception vector table.
    function automatic logic isVectorArea(input logic [22:0] addr);
        return addr[22:6] == '0;
    endfunction

endpackage

// File: rtl/c1_bus_watchdog.sv
// Bus-cycle watchdog: counts clocks of an open bus cycle that has not yet
// been acknowledged and raises berr after TIMEOUT_CYCLES of them. Once the
// cycle is acknowledged the count freezes for the rest of the cycle; berr
// holds until the cycle closes (active drops).
module c1_bus_watchdog
    import c1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic berr
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             acked;

    // Count unacknowledged clocks; an ack on the terminal edge wins over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            acked <= 1'b0;
            berr  <= 1'b0;
        end else if (!active) begin
            count <= '0;
            acked <= 1'b0;
            berr  <= 1'b0;
        end else if (!berr && !acked) begin
            if (ack)
                acked <= 1'b1;
            else if (count == LAST_COUNT)
                berr <= 1'b1;
            else
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/c1_zone_decode.sv
// C1 upstream address decode: captures the zone on the first edge of each
// 68K bus cycle, holds the active-low zone select for the whole cycle and
// supervises the cycle with a watchdog that drives nBERR.
// Build option: C1_VECTOR_SWAP_EN adds the VECT_SEL register that steers the
// vector table (0x000000-0x00007F) to the SROM zone.
//
// state  | meaning
// IDLE   | no bus cycle; waiting for nAS low
// ACTIVE | cycle open, zone held, watchdog counting until nDTACK
// ERROR  | watchdog expired, nBERR low until nAS returns high
module c1_zone_decode
    import c1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        CLK_68KCLK,
    input  logic        nRESET,
    input  logic [22:0] M68K_ADDR,
    input  logic        M68K_RW,
    input  logic        nAS,
    input  logic        nLDS,
    input  logic        nUDS,
    input  logic        nDTACK,
    output logic        nROM_ZONE,
    output logic        nWRAM_ZONE,
    output logic        nPORT_ZONE,
    output logic        nIO_ZONE,
    output logic        nCARD_ZONE,
    output logic        nSROM_ZONE,
    output logic        nBERR,
    output logic        CYCLE_ACTIVE
);

    stateT      state;
    stateT      stateNext;
    logic [3:0] addrNib;
    logic       zoneEn;
    logic       swapHit;
    logic       cycleStart;
    logic       wdActive;
    logic       wdBerr;
    zoneT       zoneCur;

    assign cycleStart = (state == IDLE) && !nAS;
    assign wdActive   = (state != IDLE) && !nAS;

    // State register.
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next state. ERROR is entered one clock after the watchdog fires; nBERR
    // itself comes straight from the watchdog flop so it is not delayed.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (!nAS) stateNext = ACTIVE;
            ACTIVE:  if (nAS) stateNext = IDLE;
                     else if (wdBerr) stateNext = ERROR;
            ERROR:   if (nAS) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Capture A[23:20] and the strobe qualification once per cycle; the latch
    // is deliberately not re-sampled while nAS stays low.
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            addrNib <= '0;
            zoneEn  <= 1'b0;
        end else if (nAS) begin
            zoneEn  <= 1'b0;
        end else if (cycleStart) begin
            addrNib <= M68K_ADDR[22:19];
            zoneEn  <= M68K_RW || !nLDS || !nUDS;
        end
    end

`ifdef C1_VECTOR_SWAP_EN
    logic vectSel;

    // VECT_SEL written by the swap-register write cycles; the vector-area
    // steering uses the value in force before this cycle's own update.
    always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
        if (!nRESET) begin
            vectSel <= 1'b1;
            swapHit <= 1'b0;
        end else if (nAS) begin
            swapHit <= 1'b0;
        end else if (cycleStart) begin
            swapHit <= vectSel && isVectorArea(M68K_ADDR);
            if (!M68K_RW && !nLDS) begin
                if (isVectSet(M68K_ADDR))
                    vectSel <= 1'b1;
                else if (isVectClr(M68K_ADDR))
                    vectSel <= 1'b0;
            end
        end
    end
`else
    // Without the swap register only A[23:20] feeds the decode.
    logic unusedAddrBits;
    assign unusedAddrBits = ^M68K_ADDR[18:0];
    assign swapHit        = 1'b0;
`endif

    // Zone select from the latched nibble; swapHit only ever accompanies a ROM nibble.
    always_comb begin
        zoneCur = ZONE_NONE;
        if (zoneEn) begin
            zoneCur = decodeNibble(addrNib);
            if (swapHit)
                zoneCur = ZONE_SROM;
        end
    end

    assign nROM_ZONE    = (zoneCur != ZONE_ROM);
    assign nWRAM_ZONE   = (zoneCur != ZONE_WRAM);
    assign nPORT_ZONE   = (zoneCur != ZONE_PORT);
    assign nIO_ZONE     = (zoneCur != ZONE_IO);
    assign nCARD_ZONE   = (zoneCur != ZONE_CARD);
    assign nSROM_ZONE   = (zoneCur != ZONE_SROM);
    assign CYCLE_ACTIVE = (state != IDLE);
    assign nBERR        = !wdBerr;

    c1_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) uWatchdog (
        .clk    (CLK_68KCLK),
        .rst    (nRESET),
        .active (wdActive),
        .ack    (!nDTACK),
        .berr   (wdBerr)
    );

endmodule

// File: tb/tb_c1_zone_decode.sv
// Self-checking bench for c1_zone_decode: a zone table, hand-written
// multi-cycle sequences and randomized bus cycles against a reference model.
module tb_c1_zone_decode;

    localparam int TO = 64;
`ifdef C1_VECTOR_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic        CLK_68KCLK = 1'b0;
    logic        nRESET;
    logic [22:0] M68K_ADDR;
    logic        M68K_RW, nAS, nLDS, nUDS, nDTACK;
    logic        nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE;
    logic        nBERR, CYCLE_ACTIVE;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit         mIn;
    logic [5:0] mZones;
    logic       mBerrN;
    int         mElapsed;
    bit         mAcked;
    bit         mVect;

    typedef struct {
        logic        nas;
        logic [23:0] a;
        logic        r, l, u;
        logic [5:0]  z;
        logic        act;
    } vecT;
    vecT tbl[20];

    always #5 CLK_68KCLK = ~CLK_68KCLK;

    c1_zone_decode #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .CLK_68KCLK   (CLK_68KCLK),
        .nRESET       (nRESET),
        .M68K_ADDR    (M68K_ADDR),
        .M68K_RW      (M68K_RW),
        .nAS          (nAS),
        .nLDS         (nLDS),
        .nUDS         (nUDS),
        .nDTACK       (nDTACK),
        .nROM_ZONE    (nROM_ZONE),
        .nWRAM_ZONE   (nWRAM_ZONE),
        .nPORT_ZONE   (nPORT_ZONE),
        .nIO_ZONE     (nIO_ZONE),
        .nCARD_ZONE   (nCARD_ZONE),
        .nSROM_ZONE   (nSROM_ZONE),
        .nBERR        (nBERR),
        .CYCLE_ACTIVE (CYCLE_ACTIVE)
    );

    // zones packed as {ROM, WRAM, PORT, IO, CARD, SROM}, active low
    function automatic logic [5:0] refZones(logic [22:0] a, logic r, logic l, logic u, bit vect);
        int b;
        b = int'({a, 1'b0});
        if (!r && l && u) return 6'b111111;
        if (SWAP && vect && b < 'h80) return 6'b111110;
        if (b < 'h100000) return 6'b011111;
        if (b < 'h200000) return 6'b101111;
        if (b < 'h300000) return 6'b110111;
        if (b < 'h400000) return 6'b111011;
        if (b < 'h800000) return 6'b111111;
        if (b < 'hC00000) return 6'b111101;
        if (b < 'hD00000) return 6'b111110;
        return 6'b111111;
    endfunction

    task automatic modelReset();
        mIn = 0; mZones = 6'b111111; mBerrN = 1'b1; mElapsed = 0; mAcked = 0; mVect = 1;
    endtask

    // One sampled clock edge of the bus, described in bus-cycle terms.
    task automatic modelEdge();
        int b;
        b = int'({M68K_ADDR, 1'b1});
        if (nAS) begin
            mIn = 0; mZones = 6'b111111; mBerrN = 1'b1; mElapsed = 0; mAcked = 0;
        end else if (!mIn) begin
            mIn = 1; mElapsed = 0; mAcked = 0;
            mZones = refZones(M68K_ADDR, M68K_RW, nLDS, nUDS, mVect);
            if (!M68K_RW && !nLDS && b == 'h3A0003) mVect = 1;
            if (!M68K_RW && !nLDS && b == 'h3A0013) mVect = 0;
        end else if (mBerrN && !mAcked) begin
            if (!nDTACK) mAcked = 1;
            else begin
                mElapsed++;
                if (mElapsed == TO) mBerrN = 1'b0;
            end
        end
    endtask

    task automatic check(input string name);
        logic [7:0] got, want;
        got  = {nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE, nBERR, CYCLE_ACTIVE};
        want = {mZones, mBerrN, mIn};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got zones=%b nBERR=%b act=%b, want zones=%b nBERR=%b act=%b",
                     name, $time, got[7:2], got[1], got[0], want[7:2], want[1], want[0]);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, got, want);
        end
    endtask

    task automatic drive(input logic asN, input logic [23:0] byteA, input logic r,
                         input logic l, input logic u, input logic d);
        nAS = asN; M68K_ADDR = byteA[23:1]; M68K_RW = r; nLDS = l; nUDS = u; nDTACK = d;
    endtask

    task automatic tick(input string name);
        @(posedge CLK_68KCLK);
        modelEdge();
        #1;
        check(name);
    endtask

    task automatic endCycle(input string name);
        drive(1'b1, 24'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(name);
    endtask

    task automatic pulseReset();
        #2 nRESET = 1'b0;
        modelReset();
        #1 check("async_reset");
        #2 nRESET = 1'b1;
    endtask

    initial begin
        logic [23:0] a1, a2;
        logic r, l, u, chg;
        int len, dAt, gap, sel;

        tbl[0]  = '{1'b0, 24'h000100, 1'b1, 1'b0, 1'b0, 6'b011111, 1'b1};
        tbl[1]  = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[2]  = '{1'b0, 24'h1ABCDE, 1'b0, 1'b0, 1'b1, 6'b101111, 1'b1};
        tbl[3]  = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[4]  = '{1'b0, 24'h2FFFFE, 1'b0, 1'b1, 1'b1, 6'b111111, 1'b1};
        tbl[5]  = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[6]  = '{1'b0, 24'h3FFFFE, 1'b1, 1'b1, 1'b1, 6'b111011, 1'b1};
        tbl[7]  = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[8]  = '{1'b0, 24'h800000, 1'b1, 1'b0, 1'b0, 6'b111101, 1'b1};
        tbl[9]  = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[10] = '{1'b0, 24'hBFFFFE, 1'b0, 1'b1, 1'b0, 6'b111101, 1'b1};
        tbl[11] = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[12] = '{1'b0, 24'hC00000, 1'b1, 1'b0, 1'b0, 6'b111110, 1'b1};
        tbl[13] = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[14] = '{1'b0, 24'h400000, 1'b1, 1'b0, 1'b0, 6'b111111, 1'b1};
        tbl[15] = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[16] = '{1'b0, 24'hD00000, 1'b0, 1'b0, 1'b1, 6'b111111, 1'b1};
        tbl[17] = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};
        tbl[18] = '{1'b0, 24'h7FFFFE, 1'b1, 1'b0, 1'b0, 6'b111111, 1'b1};
        tbl[19] = '{1'b1, 24'h000000, 1'b1, 1'b1, 1'b1, 6'b111111, 1'b0};

        // reset
        nRESET = 1'b0;
        drive(1'b1, 24'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        modelReset();
        #2 check("reset_state");
        @(posedge CLK_68KCLK);
        #1 check("reset_hold");
        #2 nRESET = 1'b1;

        // zone table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].nas, tbl[i].a, tbl[i].r, tbl[i].l, tbl[i].u, 1'b1);
            @(posedge CLK_68KCLK);
            modelEdge();
            #1;
            vectors++;
            if ({nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE, nBERR, CYCLE_ACTIVE}
                !== {tbl[i].z, 1'b1, tbl[i].act}) begin
                miscompares++;
                $display("FAIL table[%0d]: got zones=%b nBERR=%b act=%b, want zones=%b nBERR=1 act=%b", i,
                         {nROM_ZONE, nWRAM_ZONE, nPORT_ZONE, nIO_ZONE, nCARD_ZONE, nSROM_ZONE},
                         nBERR, CYCLE_ACTIVE, tbl[i].z, tbl[i].act);
            end
        end

        // ROM read acknowledged at edge 4
        drive(1'b0, 24'h000100, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("rom_entry");
        for (int j = 1; j <= 10; j++) begin
            drive(1'b0, 24'h000100, 1'b1, 1'b0, 1'b0, (j >= 4) ? 1'b0 : 1'b1);
            tick("rom_cycle");
            checkBit("rom_sel_held", nROM_ZONE, 1'b0);
            checkBit("rom_no_berr", nBERR, 1'b1);
        end
        endCycle("rom_end");
        checkBit("rom_release", nROM_ZONE, 1'b1);

        // write with no strobes, never acknowledged
        drive(1'b0, 24'h2FFFFE, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("wd_write_entry");
        for (int j = 1; j <= 70; j++) begin
            tick("wd_write");
            if (j == TO - 1) checkBit("berr_before_timeout", nBERR, 1'b1);
            if (j == TO) checkBit("berr_at_timeout", nBERR, 1'b0);
        end
        endCycle("wd_write_end");
        checkBit("berr_release", nBERR, 1'b1);

        // unmapped read, never acknowledged
        drive(1'b0, 24'h500000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("wd_unmapped_entry");
        for (int j = 1; j <= 66; j++) begin
            tick("wd_unmapped");
            if (j == TO) checkBit("unmapped_berr", nBERR, 1'b0);
        end
        endCycle("wd_unmapped_end");

        // address moves mid-cycle
        drive(1'b0, 24'h100000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("hold_entry");
        for (int j = 1; j <= 5; j++) begin
            drive(1'b0, 24'hC00000, 1'b1, 1'b0, 1'b0, 1'b1);
            tick("hold_cycle");
            checkBit("hold_wram", nWRAM_ZONE, 1'b0);
            checkBit("hold_no_srom", nSROM_ZONE, 1'b1);
        end
        endCycle("hold_end");

        // async reset mid ROM cycle
        drive(1'b0, 24'h000200, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("rst_entry");
        for (int j = 1; j <= 3; j++) tick("rst_cycle");
        pulseReset();
        checkBit("rst_rom_cleared", nROM_ZONE, 1'b1);
        tick("rst_reentry");
        checkBit("rst_rom_again", nROM_ZONE, 1'b0);
        endCycle("rst_end");

        // acknowledge on the timeout edge
        drive(1'b0, 24'h100000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("tie_entry");
        for (int j = 1; j <= 68; j++) begin
            drive(1'b0, 24'h100000, 1'b1, 1'b0, 1'b0, (j >= TO) ? 1'b0 : 1'b1);
            tick("tie_cycle");
            if (j >= TO) checkBit("tie_no_berr", nBERR, 1'b1);
        end
        endCycle("tie_end");

        // back-to-back cycles with a single idle clock
        drive(1'b0, 24'h300000, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) tick("b2b_first");
        endCycle("b2b_gap");
        checkBit("b2b_gap_idle", CYCLE_ACTIVE, 1'b0);
        drive(1'b0, 24'h200000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("b2b_second");
        checkBit("b2b_port", nPORT_ZONE, 1'b0);
        checkBit("b2b_not_io", nIO_ZONE, 1'b1);
        endCycle("b2b_end");

        // vector table steering
        pulseReset();
        drive(1'b0, 24'h000004, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("vect_read0");
`ifdef C1_VECTOR_SWAP_EN
        checkBit("vect_default_srom", nSROM_ZONE, 1'b0);
`else
        checkBit("vect_default_rom", nROM_ZONE, 1'b0);
`endif
        endCycle("vect_end0");
        drive(1'b0, 24'h3A0013, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("vect_clr_write");
        endCycle("vect_end1");
        drive(1'b0, 24'h000004, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("vect_read1");
        checkBit("vect_cleared_rom", nROM_ZONE, 1'b0);
        endCycle("vect_end2");
        drive(1'b0, 24'h3A0003, 1'b0, 1'b0, 1'b1, 1'b1);
        tick("vect_set_write");
        endCycle("vect_end3");
        drive(1'b0, 24'h000004, 1'b1, 1'b0, 1'b0, 1'b1);
        tick("vect_read2");
`ifdef C1_VECTOR_SWAP_EN
        checkBit("vect_set_srom", nSROM_ZONE, 1'b0);
`else
        checkBit("vect_set_rom", nROM_ZONE, 1'b0);
`endif
        endCycle("vect_end4");

        // randomized bus cycles
        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) a1 = 24'($urandom_range(0, 'h7F));
            else if (sel == 2) a1 = ($urandom % 2) ? 24'h3A0003 : 24'h3A0013;
            else a1 = 24'($urandom);
            a2  = 24'($urandom);
            chg = ($urandom % 4) == 0;
            r   = 1'($urandom);
            sel = $urandom_range(0, 3);
            l   = (sel == 0 || sel == 2) ? 1'b0 : 1'b1;
            u   = (sel == 1 || sel == 2) ? 1'b0 : 1'b1;
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 8);
            dAt = $urandom_range(1, len + 3);
            for (int j = 0; j < len; j++) begin
                drive(1'b0, (j > 0 && chg) ? a2 : a1, r, l, u, (j > 0 && j >= dAt) ? 1'b0 : 1'b1);
                tick("random_cycle");
            end
            gap = $urandom_range(1, 3);
            for (int j = 0; j < gap; j++) begin
                drive(1'b1, 24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                tick("random_idle");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
